// File: rtl/dffe_pipe.sv
// dffe_pipe: elastic valid/ready pipeline with per-bit write-enable merge against a shadow word
module dffe_pipe #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               d,
  input  logic [W-1:0]               ena,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               q,
  output logic [W-1:0]               shadow,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] valid_q, valid_d, go;
  logic [W-1:0] data_q [DEPTH];
  logic [W-1:0] data_d [DEPTH];
  logic [W-1:0] shadow_q, shadow_d, m;
  logic [CW-1:0] count_q, count_d;
  logic pop, accept;
  assign pop = valid_q[DEPTH-1] && out_ready;
  assign m = (ena & d) | (~ena & shadow_q);
  assign in_ready = !clr && !flush && (!valid_q[0] || go[0]);
  assign accept = in_valid && in_ready;
  assign q = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign shadow = shadow_q;
  assign count = count_q;
  // a stage vacates when the last stage pops or any stage above it is empty (bubble collapse)
  always_comb begin
    for (int k = 0; k < DEPTH; k++) go[k] = valid_q[k] && (pop || (((~valid_q) >> (k + 1)) != '0));
  end
  // next-state: shift valid words forward, flush drops valid bits but leaves data frozen
  always_comb begin
    valid_d[0] = accept || (valid_q[0] && !go[0]);
    data_d[0] = accept ? m : data_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = go[k-1] || (valid_q[k] && !go[k]);
      data_d[k] = (go[k-1] && !flush) ? data_q[k-1] : data_q[k];
    end
    if (flush) valid_d = '0;
    shadow_d = accept ? m : shadow_q;
    count_d = flush ? '0 : count_q + CW'(accept) - CW'(pop);
  end
  // state registers; clr overrides every other update
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      data_q <= '{default: RESET_VAL};
      shadow_q <= RESET_VAL;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      shadow_q <= shadow_d;
      count_q <= count_d;
    end
  end
endmodule
